// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// ex_stage_pkg : shared widths, ALU op codes and result-FIFO state encoding
// Revision     : 1.0
// ============================================================================
package ex_stage_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 3;
    localparam int IMM_W  = 3;

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_AND = 2'd2;
    localparam logic [1:0] c_OP_OR  = 2'd3;

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    typedef struct packed {
        logic              wr;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic [DATA_W-1:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_alu.sv
`default_nettype none
// ============================================================================
// ex_alu : operand-B select (register or sign-extended immediate) and 4-op ALU
// Revision : 1.0
// ============================================================================
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [IMM_W-1:0]  i_imm,
    input  logic              i_sign_extend_sel,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] w_op_b;

    assign w_op_b = i_sign_extend_sel ? sign_ext_imm(i_imm) : i_data2;

    always_comb begin
        o_result = '0;
        case (i_op)
            c_OP_ADD: o_result = i_op_a + w_op_b;
            c_OP_SUB: o_result = i_op_a - w_op_b;
            c_OP_AND: o_result = i_op_a & w_op_b;
            c_OP_OR:  o_result = i_op_a | w_op_b;
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage : execute stage with two-entry result FIFO (head + skid) and
//            operand-A forwarding from results still buffered in the FIFO
// Revision : 1.0
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_extend_sel,
    input  logic              write_reg,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [IMM_W-1:0]  unextended,
    input  logic [1:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_write_reg,
    output logic [REG_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_data
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_in_ready;
    entry_t            r_head;
    entry_t            r_skid;
    entry_t            w_new;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_xfer;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_result;

    assign w_out_valid = (r_state != c_ST_EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_xfer      = w_out_valid & out_ready;

    // Skid is younger than head, so it wins when both match.
    always_comb begin
        w_op_a = data1;
        if (rs1 != '0) begin
            if ((r_state == c_ST_FULL) && r_skid.wr && (r_skid.rd == rs1)) begin
                w_op_a = r_skid.data;
            end else if (w_out_valid && r_head.wr && (r_head.rd == rs1)) begin
                w_op_a = r_head.data;
            end
        end
    end

    ex_alu u_alu (
        .i_op_a            (w_op_a),
        .i_data2           (data2),
        .i_imm             (unextended),
        .i_sign_extend_sel (sign_extend_sel),
        .i_op              (op),
        .o_result          (w_result)
    );

    always_comb begin
        w_new      = '0;
        w_new.wr   = write_reg;
        w_new.rd   = rd;
        w_new.data = w_result;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_EMPTY: if (w_accept) w_state_nxt = c_ST_ONE;
            c_ST_ONE: begin
                if (w_accept && !w_xfer)      w_state_nxt = c_ST_FULL;
                else if (!w_accept && w_xfer) w_state_nxt = c_ST_EMPTY;
            end
            c_ST_FULL:  if (w_xfer) w_state_nxt = c_ST_ONE;
            default:    w_state_nxt = c_ST_EMPTY;
        endcase
    end

    // in_ready is a flop so it never has a combinational path from out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_EMPTY;
            r_in_ready <= 1'b0;
            r_head     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != c_ST_FULL);
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) r_head <= w_new;
                end
                c_ST_ONE: begin
                    if (w_accept && w_xfer) r_head <= w_new;
                    else if (w_accept)      r_skid <= w_new;
                end
                c_ST_FULL: begin
                    if (w_xfer) r_head <= r_skid;
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = w_out_valid;
    assign out_write_reg = w_out_valid & r_head.wr;
    assign out_rd        = r_head.rd;
    assign out_data      = r_head.data;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_stage : directed + random checks of ex_stage against a queue model
// Revision    : 1.0
// ============================================================================
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       sign_extend_sel = 1'b0;
    logic       write_reg = 1'b0;
    logic [2:0] rs1 = '0;
    logic [2:0] rd = '0;
    logic [7:0] data1 = '0;
    logic [7:0] data2 = '0;
    logic [2:0] unextended = '0;
    logic [1:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_write_reg;
    logic [2:0] out_rd;
    logic [7:0] out_data;

    ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .sign_extend_sel (sign_extend_sel),
        .write_reg       (write_reg),
        .rs1             (rs1),
        .rd              (rd),
        .data1           (data1),
        .data2           (data2),
        .unextended      (unextended),
        .op              (op),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_write_reg   (out_write_reg),
        .out_rd          (out_rd),
        .out_data        (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] rd;
        logic [7:0] data;
    } ent_t;

    ent_t       q[$];
    bit         m_live = 1'b0;
    bit         m_stall = 1'b0;
    bit         seen_valid = 1'b0;
    logic       p_wr;
    logic [2:0] p_rd;
    logic [7:0] p_data;
    int         n_assert = 0;
    int         n_fail = 0;
    int         n_acc = 0;
    int         n_dut_del = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result of the instruction currently on the inputs, from the architectural rules.
    function automatic logic [7:0] ref_result();
        int a;
        int b;
        int r;
        bit found;
        a = int'(data1);
        found = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!found && q[i].wr && q[i].rd == rs1 && rs1 != 3'd0) begin
                a = int'(q[i].data);
                found = 1'b1;
            end
        end
        if (sign_extend_sel) b = (unextended >= 3'd4) ? int'(unextended) - 8 : int'(unextended);
        else                 b = int'(data2);
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        return r[7:0];
    endfunction

    task automatic model_edge();
        bit   acc;
        bit   xf;
        ent_t e;
        if (reset) begin
            q.delete();
            m_live  = 1'b0;
            m_stall = 1'b0;
            return;
        end
        if (seen_valid && out_ready) n_dut_del++;
        acc     = in_valid && m_live && (q.size() < 2);
        xf      = (q.size() > 0) && out_ready;
        m_stall = (q.size() > 0) && !out_ready;
        e.wr = write_reg; e.rd = rd; e.data = 8'h00;
        if (acc) e.data = ref_result();
        if (xf) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            n_acc++;
        end
        m_live = 1'b1;
    endtask

    task automatic check_outputs();
        check("in_ready", 32'(in_ready), 32'(m_live && q.size() < 2));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("out_write_reg", 32'(out_write_reg), 32'(q[0].wr));
            check("out_rd", 32'(out_rd), 32'(q[0].rd));
            check("out_data", 32'(out_data), 32'(q[0].data));
        end else begin
            check("idle_write_reg", 32'(out_write_reg), 32'd0);
        end
        if (m_stall) begin
            check("stall_wr", 32'(out_write_reg), 32'(p_wr));
            check("stall_rd", 32'(out_rd), 32'(p_rd));
            check("stall_data", 32'(out_data), 32'(p_data));
        end
        p_wr = out_write_reg; p_rd = out_rd; p_data = out_data;
        seen_valid = out_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit sel, input bit wr, input logic [2:0] s1,
                         input logic [2:0] d, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] imm, input logic [1:0] o);
        in_valid = v; sign_extend_sel = sel; write_reg = wr; rs1 = s1; rd = d;
        data1 = a; data2 = b; unextended = imm; op = o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) tick();
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // ADD with sign-extended -1, then SUB and AND
        out_ready = 1'b1;
        drive(1, 1, 1, 3'd1, 3'd2, 8'h7F, 8'h00, 3'b111, c_OP_ADD);
        tick();
        check("add_imm_data", 32'(out_data), 32'h7E);
        check("add_imm_valid", 32'(out_valid), 32'd1);
        drive(1, 0, 1, 3'd5, 3'd4, 8'h00, 8'h01, 3'd0, c_OP_SUB);
        tick();
        check("sub_wrap", 32'(out_data), 32'hFF);
        drive(1, 0, 1, 3'd6, 3'd1, 8'hF0, 8'h3C, 3'd0, c_OP_AND);
        tick();
        check("and_bits", 32'(out_data), 32'h30);
        in_valid = 1'b0;
        tick();

        // Back-to-back accepts while stalled fill the FIFO
        out_ready = 1'b0;
        drive(1, 0, 1, 3'd1, 3'd5, 8'h01, 8'h02, 3'd0, c_OP_ADD);
        tick();
        drive(1, 0, 1, 3'd2, 3'd6, 8'h50, 8'h05, 3'd0, c_OP_OR);
        tick();
        in_valid = 1'b0;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", 32'(out_data), 32'h03);
        tick();
        check("full_hold", 32'(out_data), 32'h03);
        out_ready = 1'b1;
        tick();
        check("b2b_second", 32'(out_data), 32'h55);
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        tick();
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_wr", 32'(out_write_reg), 32'd0);
        check("drained_rd_hold", 32'(out_rd), 32'd6);
        check("drained_data_hold", 32'(out_data), 32'h55);

        // Forwarding from a held result, and rd=0 never forwards
        out_ready = 1'b0;
        drive(1, 0, 1, 3'd0, 3'd3, 8'h10, 8'h00, 3'd0, c_OP_ADD);
        tick();
        drive(1, 1, 1, 3'd3, 3'd7, 8'h00, 8'h00, 3'd1, c_OP_ADD);
        tick();
        in_valid = 1'b0;
        check("fwd_producer", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        tick();
        check("fwd_rd3", 32'(out_data), 32'h11);
        tick();
        out_ready = 1'b0;
        drive(1, 0, 1, 3'd0, 3'd0, 8'h10, 8'h00, 3'd0, c_OP_ADD);
        tick();
        drive(1, 1, 1, 3'd0, 3'd7, 8'h00, 8'h00, 3'd1, c_OP_ADD);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fwd_rd0", 32'(out_data), 32'h01);
        tick();

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        drive(1, 0, 1, 3'd0, 3'd1, 8'h01, 8'h01, 3'd0, c_OP_ADD);
        tick();
        drive(1, 0, 1, 3'd0, 3'd2, 8'h02, 8'h02, 3'd0, c_OP_ADD);
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b1;
        q.delete();
        m_live = 1'b0;
        m_stall = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_wr", 32'(out_write_reg), 32'd0);
        check("arst_rd", 32'(out_rd), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        tick();
        check("post_rst_no_stale2", 32'(out_valid), 32'd0);

        // Random traffic
        n_acc = 0;
        n_dut_del = 0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("rand_drained", 32'(out_valid), 32'd0);
        check("rand_no_loss_dup", 32'(n_dut_del), 32'(n_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
